alu_issue_decode: RTL

ALU_ISSUE_DECODE -- requirements
Module: alu_issue_decode

---
 rtl/alu_issue_decode_if.sv | 28 ++
 rtl/alu_issue_decode.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_decode_if.sv
// Handshake bundle between the issue stage, the decode buffer and the ALU stage.
// The slave side is the decode buffer; the master side is its upstream/downstream environment.
interface alu_issue_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] illegal_count;

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_opcode, rd, illegal, illegal_count
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_opcode, rd, illegal, illegal_count
    );
endinterface

// File: rtl/alu_issue_decode.sv
// RV64 integer ALU decode at issue, buffered in a 2-entry in-order FIFO that holds decoded
// operands/opcode; tracks a saturating count of accepted illegal instructions.
module alu_issue_decode (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_decode_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  opcode;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [3:0] OP_SLL     = 4'b0001;
    localparam logic [3:0] OP_SRL     = 4'b0101;
    localparam logic [3:0] OP_SUB     = 4'b1000;
    localparam logic [3:0] OP_SRA     = 4'b1101;
    localparam logic [3:0] OP_ILL     = 4'b1111;

    // Illegal encodings collapse to a fixed zero-operand entry so downstream never sees stale data.
    function automatic entry_t decode(input logic [31:0] instr,
                                      input logic [63:0] rs1,
                                      input logic [63:0] rs2);
        entry_t     e;
        logic       ok;
        logic [3:0] op;
        e  = '0;
        ok = 1'b0;
        op = OP_ILL;
        case (instr[6:0])
            OPC_OP: begin
                e.a = rs1;
                e.b = rs2;
                if (instr[31:25] == 7'b0000000) begin
                    op = {1'b0, instr[14:12]};
                    ok = 1'b1;
                end else if (instr[31:25] == 7'b0100000 && instr[14:12] == 3'b000) begin
                    op = OP_SUB;
                    ok = 1'b1;
                end else if (instr[31:25] == 7'b0100000 && instr[14:12] == 3'b101) begin
                    op = OP_SRA;
                    ok = 1'b1;
                end else begin
                    ok = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                e.a = rs1;
                case (instr[14:12])
                    3'b001: begin
                        e.b = {58'd0, instr[25:20]};
                        if (instr[31:26] == 6'b000000) begin
                            op = OP_SLL;
                            ok = 1'b1;
                        end else begin
                            ok = 1'b0;
                        end
                    end
                    3'b101: begin
                        e.b = {58'd0, instr[25:20]};
                        if (instr[31:26] == 6'b000000) begin
                            op = OP_SRL;
                            ok = 1'b1;
                        end else if (instr[31:26] == 6'b010000) begin
                            op = OP_SRA;
                            ok = 1'b1;
                        end else begin
                            ok = 1'b0;
                        end
                    end
                    default: begin
                        e.b = {{52{instr[31]}}, instr[31:20]};
                        op  = {1'b0, instr[14:12]};
                        ok  = 1'b1;
                    end
                endcase
            end
            default: begin
                ok = 1'b0;
            end
        endcase
        e.rd = instr[11:7];
        if (ok) begin
            e.opcode  = op;
            e.illegal = 1'b0;
        end else begin
            e.opcode  = OP_ILL;
            e.a       = 64'd0;
            e.b       = 64'd0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    state_e      state_r, state_n;
    entry_t      head_r, head_n;
    entry_t      tail_r, tail_n;
    entry_t      dec_s;
    logic        in_ready_r, in_ready_n;
    logic        out_valid_r, out_valid_n;
    logic [15:0] count_r, count_n;
    logic        accept_s;
    logic        pop_s;

    // Next-state, FIFO entry movement and illegal counter update.
    always_comb begin
        accept_s = bus.in_valid && in_ready_r;
        pop_s    = out_valid_r && bus.out_ready;
        dec_s    = decode(bus.instr, bus.rs1_data, bus.rs2_data);
        state_n  = state_r;
        head_n   = head_r;
        tail_n   = tail_r;
        count_n  = count_r;
        if (bus.flush) begin
            state_n = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_n  = dec_s;
                        state_n = ST_ONE;
                    end else begin
                        state_n = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        head_n  = dec_s;
                        state_n = ST_ONE;
                    end else if (accept_s) begin
                        tail_n  = dec_s;
                        state_n = ST_FULL;
                    end else if (pop_s) begin
                        state_n = ST_EMPTY;
                    end else begin
                        state_n = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        head_n  = tail_r;
                        state_n = ST_ONE;
                    end else begin
                        state_n = ST_FULL;
                    end
                end
                default: begin
                    state_n = ST_EMPTY;
                end
            endcase
        end
        // An empty buffer must never advertise an illegal head.
        if (state_n == ST_EMPTY) begin
            head_n.illegal = 1'b0;
        end else begin
            head_n.illegal = head_n.illegal;
        end
        if (accept_s && dec_s.illegal && !bus.flush && count_r != 16'hFFFF) begin
            count_n = count_r + 16'd1;
        end else begin
            count_n = count_r;
        end
        in_ready_n  = (state_n != ST_FULL);
        out_valid_n = (state_n != ST_EMPTY);
    end

    // State, buffered entries, handshake flags and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            head_r      <= '0;
            tail_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            count_r     <= 16'd0;
        end else begin
            state_r     <= state_n;
            head_r      <= head_n;
            tail_r      <= tail_n;
            in_ready_r  <= in_ready_n;
            out_valid_r <= out_valid_n;
            count_r     <= count_n;
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.alu_a         = head_r.a;
    assign bus.alu_b         = head_r.b;
    assign bus.alu_opcode    = head_r.opcode;
    assign bus.rd            = head_r.rd;
    assign bus.illegal       = head_r.illegal;
    assign bus.illegal_count = count_r;

endmodule
